// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared constants and state type for the RV32M divide sequencer
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [2:0] MDU_DIV  = 3'b100;
    localparam logic [2:0] MDU_DIVU = 3'b101;
    localparam logic [2:0] MDU_REM  = 3'b110;
    localparam logic [2:0] MDU_REMU = 3'b111;

    localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } div_state_t;

    // funct3[0] clear marks the signed variants (DIV, REM)
    function automatic logic is_signed_op(input logic [2:0] op);
        return !op[0];
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - execute-stage request/response bundle for the divide sequencer
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, src_a, src_b, flush,
        input  stall, busy, valid, result
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output stall, busy, valid, result
    );

endinterface

// File: rtl/div_sequencer_step.sv
// rtl/div_sequencer_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic           w_ge;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});

    // the true difference is below the divisor, so the low WIDTH bits are exact
    assign o_rem = w_ge ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle DIV/DIVU/REM/REMU sequencer with RISC-V special cases
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    div_sequencer_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       r_state;
    div_state_t       w_next;
    logic             r_rem_sel;
    logic             r_neg_a;
    logic             r_neg_b;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_signed;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_last;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_accept   = (r_state == ST_IDLE) && bus.start && bus.op[2] && !bus.flush;
    assign w_signed   = is_signed_op(bus.op);
    assign w_div_zero = (bus.src_b == '0);
    assign w_ovf      = w_signed && (bus.src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.src_b == '1);
    assign w_a_neg    = w_signed && bus.src_a[WIDTH-1];
    assign w_b_neg    = w_signed && bus.src_b[WIDTH-1];
    assign w_last     = (r_cnt == CW'(WIDTH-1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    assign w_quo_fix = (r_neg_a ^ r_neg_b) ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_a ? -r_rem : r_rem;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = (w_div_zero || w_ovf) ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last) w_next = ST_FIX;
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (bus.flush) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rem_sel <= 1'b0;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_result  <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rem_sel <= bus.op[1];
                        r_neg_a   <= w_a_neg;
                        r_neg_b   <= w_b_neg;
                        r_quo     <= w_a_neg ? -bus.src_a : bus.src_a;
                        r_div     <= w_b_neg ? -bus.src_b : bus.src_b;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        // special cases resolve here and skip straight to DONE
                        if (w_div_zero)
                            r_result <= bus.op[1] ? bus.src_a : '1;
                        else if (w_ovf)
                            r_result <= bus.op[1] ? '0 : bus.src_a;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                end
                ST_FIX: begin
                    if (!bus.flush) r_result <= r_rem_sel ? w_rem_fix : w_quo_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall  = w_accept || (r_state == ST_CALC) || (r_state == ST_FIX);
    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.valid  = (r_state == ST_DONE) && !bus.flush;
    assign bus.result = r_result;

endmodule
